// File: rtl/ac97_pkg.sv
// Shared constants for the AC97 CSR scheduler: CSR register map, channel mode codes,
// sequencer state type and the DMA ring-address helper.
package ac97_pkg;

  localparam logic [13:0] CSR_CTRL       = 14'h00;
  localparam logic [13:0] CSR_PLAY_START = 14'h10;
  localparam logic [13:0] CSR_PLAY_ADDR  = 14'h14;
  localparam logic [13:0] CSR_REC_START  = 14'h20;
  localparam logic [13:0] CSR_REC_ADDR   = 14'h24;

  localparam logic [31:0] MODE_PLAY = 32'd1;
  localparam logic [31:0] MODE_REC  = 32'd3;
  localparam logic [31:0] START_GO  = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CTRL  = 2'd1,
    ST_ADDR  = 2'd2,
    ST_START = 2'd3
  } sched_state_t;

  // Step an address around its ring; the offset is taken modulo 2^32 so a ring
  // straddling the top of the address space still wraps back to its base.
  function automatic logic [31:0] ring_next(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] step,
                                            input logic [31:0] size);
    logic [31:0] nxt;
    nxt = addr + step;
    if ((nxt - base) >= size) return base;
    return nxt;
  endfunction

endpackage

// File: rtl/ac97_rr_arb.sv
// Two-way round-robin arbiter: bit 0 = playback, bit 1 = record.
// After reset record counts as last served, so playback wins the first tie.
module ac97_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_rec;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_rec ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_rec <= 1'b1;
    else if (update && (grant != 2'b00))
      last_rec <= grant[1];
  end

endmodule

// File: rtl/ac97_csr_sched.sv
// AC97 CSR scheduler: issues the CTRL/ADDR/START write triple for whichever DMA
// channel is pending. Define AC97_SCHED_TIMEOUT_EN to add the CSR ack watchdog.
module ac97_csr_sched
  import ac97_pkg::*;
#(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned BUF_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_en,
  input  logic        rec_en,
  input  logic        dmar_irq,
  input  logic        dmaw_irq,
  input  logic [31:0] play_base,
  input  logic [31:0] rec_base,
  output logic        csr_req,
  input  logic        csr_ack,
  output logic [13:0] csr_addr,
  output logic [31:0] csr_data,
  output logic        busy,
  output logic [31:0] play_addr,
  output logic [31:0] rec_addr,
  output logic        err
);

  localparam logic [31:0] STEP = 32'(ADDR_STEP);
  localparam logic [31:0] RING = 32'(BUF_BYTES);

  sched_state_t state;
  logic       sel_rec;
  logic [1:0] en;
  logic [1:0] en_q;
  logic [1:0] rise;
  logic [1:0] irq_en;
  logic [1:0] pend;
  logic [1:0] pend_d;
  logic [1:0] grant;
  logic [1:0] grant_take;
  logic [1:0] abort_clr;
  logic       update;
  logic       abort;

  assign en     = {rec_en, play_en};
  assign rise   = en & ~en_q;
  assign irq_en = {dmaw_irq, dmar_irq} & en;
  assign busy   = (state != ST_IDLE);
  assign update = (state == ST_IDLE) && (pend != 2'b00);

  ac97_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (pend),
    .update (update),
    .grant  (grant)
  );

  // A new request in the same cycle as the grant must survive so it is served
  // after the sequence that is just starting; a disabled channel drops its request.
  assign grant_take = update ? grant : 2'b00;
  assign abort_clr  = abort ? (sel_rec ? 2'b10 : 2'b01) : 2'b00;
  assign pend_d     = ((pend & en & ~grant_take) | rise | irq_en) & ~abort_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 2'b00;
      pend <= 2'b00;
    end else begin
      en_q <= en;
      pend <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      play_addr <= '0;
      rec_addr  <= '0;
    end else begin
      if (rise[0])
        play_addr <= play_base;
      else if (irq_en[0])
        play_addr <= ring_next(play_addr, play_base, STEP, RING);
      if (rise[1])
        rec_addr <= rec_base;
      else if (irq_en[1])
        rec_addr <= ring_next(rec_addr, rec_base, STEP, RING);
    end
  end

`ifdef AC97_SCHED_TIMEOUT_EN
  logic [7:0] wdog;
  logic       err_q;
  logic       stall;

  assign stall = csr_req & ~csr_ack;
  // The 255th consecutive unacknowledged cycle triggers the abort.
  assign abort = stall && (wdog == 8'd254);
  assign err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog  <= 8'd0;
      err_q <= 1'b0;
    end else if (abort) begin
      wdog  <= 8'd0;
      err_q <= 1'b1;
    end else if (stall) begin
      wdog <= wdog + 8'd1;
    end else begin
      wdog <= 8'd0;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  // Sequencer: every write is held on the bus until the cycle it is acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_rec  <= 1'b0;
      csr_req  <= 1'b0;
      csr_addr <= '0;
      csr_data <= '0;
    end else if (abort) begin
      state    <= ST_IDLE;
      csr_req  <= 1'b0;
      csr_addr <= '0;
      csr_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pend != 2'b00) begin
            state    <= ST_CTRL;
            sel_rec  <= grant[1];
            csr_req  <= 1'b1;
            csr_addr <= CSR_CTRL;
            csr_data <= grant[1] ? MODE_REC : MODE_PLAY;
          end
        end
        ST_CTRL: begin
          if (csr_ack) begin
            state    <= ST_ADDR;
            csr_addr <= sel_rec ? CSR_REC_ADDR : CSR_PLAY_ADDR;
            csr_data <= sel_rec ? rec_addr : play_addr;
          end
        end
        ST_ADDR: begin
          if (csr_ack) begin
            state    <= ST_START;
            csr_addr <= sel_rec ? CSR_REC_START : CSR_PLAY_START;
            csr_data <= START_GO;
          end
        end
        ST_START: begin
          if (csr_ack) begin
            state    <= ST_IDLE;
            csr_req  <= 1'b0;
            csr_addr <= '0;
            csr_data <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac97_csr_sched.sv
// Self-checking bench for ac97_csr_sched (ring of 16 bytes, step 4): vector table,
// directed corner sequences and a randomized run against a transaction-level model.
module tb_ac97_csr_sched;

  localparam int STEP = 4;
  localparam int BUF  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play_en = 1'b0, rec_en = 1'b0, dmar_irq = 1'b0, dmaw_irq = 1'b0;
  logic        csr_ack = 1'b0;
  logic [31:0] play_base = 32'h1000, rec_base = 32'h2000;
  logic        csr_req, busy, err;
  logic [13:0] csr_addr;
  logic [31:0] csr_data, play_addr, rec_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ac97_csr_sched #(.ADDR_STEP(STEP), .BUF_BYTES(BUF)) dut (
    .clk(clk), .rst(rst), .play_en(play_en), .rec_en(rec_en),
    .dmar_irq(dmar_irq), .dmaw_irq(dmaw_irq), .play_base(play_base), .rec_base(rec_base),
    .csr_req(csr_req), .csr_ack(csr_ack), .csr_addr(csr_addr), .csr_data(csr_data),
    .busy(busy), .play_addr(play_addr), .rec_addr(rec_addr), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          model_on = 1'b0;
  bit [1:0]    m_pend, m_enq;
  bit          m_last_rec;
  int          m_left, m_idx, m_ch;
  logic [31:0] m_addr [2];
  logic [13:0] m_wa [3];
  logic [31:0] m_wd [3];

  task automatic model_reset();
    m_pend = 2'b00; m_enq = 2'b00; m_last_rec = 1'b1;
    m_left = 0; m_idx = 0; m_ch = 0;
    m_addr[0] = 32'h0; m_addr[1] = 32'h0;
  endtask

  // Applies the rules for one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    bit [1:0]    en, irq, took;
    logic [31:0] base [2];
    bit          rise, adv;
    en = {rec_en, play_en};
    irq = {dmaw_irq, dmar_irq};
    base[0] = play_base; base[1] = rec_base;
    took = 2'b00;
    if (m_left > 0) begin
      if (csr_ack) begin
        if (m_idx == 0) m_wd[1] = m_addr[m_ch];
        m_idx++;
        m_left--;
      end
    end else if (m_pend != 2'b00) begin
      if (m_pend == 2'b11) m_ch = m_last_rec ? 0 : 1;
      else m_ch = m_pend[1] ? 1 : 0;
      m_last_rec = (m_ch == 1);
      took[m_ch] = 1'b1;
      m_idx = 0; m_left = 3;
      m_wa[0] = 14'h00;                    m_wd[0] = (m_ch == 1) ? 32'd3 : 32'd1;
      m_wa[1] = (m_ch == 1) ? 14'h24 : 14'h14; m_wd[1] = 32'h0;
      m_wa[2] = (m_ch == 1) ? 14'h20 : 14'h10; m_wd[2] = 32'd1;
    end
    for (int c = 0; c < 2; c++) begin
      rise = en[c] && !m_enq[c];
      adv  = irq[c] && en[c];
      m_pend[c] = (m_pend[c] && en[c] && !took[c]) || rise || adv;
      if (rise) m_addr[c] = base[c];
      else if (adv) m_addr[c] = base[c] + ((m_addr[c] - base[c] + STEP) % BUF);
      m_enq[c] = en[c];
    end
  endtask

  task automatic model_check();
    chk("rnd_req", csr_req, m_left > 0);
    chk("rnd_busy", busy, m_left > 0);
    if (m_left > 0) begin
      chk("rnd_addr", csr_addr, m_wa[m_idx]);
      chk("rnd_data", csr_data, m_wd[m_idx]);
    end
    chk("rnd_play_addr", play_addr, m_addr[0]);
    chk("rnd_rec_addr", rec_addr, m_addr[1]);
    chk("rnd_err", err, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on && !rst) model_edge();
    @(negedge clk);
    if (model_on && !rst) model_check();
  endtask

  task automatic do_reset(input logic [31:0] pb, input logic [31:0] rb);
    rst = 1'b1;
    play_en = 1'b0; rec_en = 1'b0; dmar_irq = 1'b0; dmaw_irq = 1'b0; csr_ack = 1'b0;
    play_base = pb; rec_base = rb;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  in;    // {play_en, rec_en, dmar_irq, dmaw_irq, csr_ack}
    logic        req;
    logic [13:0] a;
    logic [31:0] d;
    logic        bsy;
    logic [31:0] pa;
    logic [31:0] ra;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] in, input logic req, input logic [13:0] a,
                              input logic [31:0] d, input logic bsy,
                              input logic [31:0] pa, input logic [31:0] ra);
    vec_t v;
    v.in = in; v.req = req; v.a = a; v.d = d; v.bsy = bsy; v.pa = pa; v.ra = ra;
    return v;
  endfunction

  vec_t tv [24];

  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];

  initial begin
    // play start, then a play irq with a 5-cycle ack stall in ADDR, then record wrap
    tv[0]  = mk(5'b10001, 1'b0, 14'h00, 32'h0,    1'b0, 32'h1000, 32'h0);
    tv[1]  = mk(5'b10001, 1'b1, 14'h00, 32'h1,    1'b1, 32'h1000, 32'h0);
    tv[2]  = mk(5'b10001, 1'b1, 14'h14, 32'h1000, 1'b1, 32'h1000, 32'h0);
    tv[3]  = mk(5'b10001, 1'b1, 14'h10, 32'h1,    1'b1, 32'h1000, 32'h0);
    tv[4]  = mk(5'b10001, 1'b0, 14'h00, 32'h0,    1'b0, 32'h1000, 32'h0);
    tv[5]  = mk(5'b10100, 1'b0, 14'h00, 32'h0,    1'b0, 32'h1004, 32'h0);
    tv[6]  = mk(5'b10000, 1'b1, 14'h00, 32'h1,    1'b1, 32'h1004, 32'h0);
    tv[7]  = mk(5'b10001, 1'b1, 14'h14, 32'h1004, 1'b1, 32'h1004, 32'h0);
    for (int i = 8; i <= 12; i++)
      tv[i] = mk(5'b10000, 1'b1, 14'h14, 32'h1004, 1'b1, 32'h1004, 32'h0);
    tv[13] = mk(5'b10001, 1'b1, 14'h10, 32'h1,    1'b1, 32'h1004, 32'h0);
    tv[14] = mk(5'b10001, 1'b0, 14'h00, 32'h0,    1'b0, 32'h1004, 32'h0);
    tv[15] = mk(5'b11001, 1'b0, 14'h00, 32'h0,    1'b0, 32'h1004, 32'h2000);
    tv[16] = mk(5'b11011, 1'b1, 14'h00, 32'h3,    1'b1, 32'h1004, 32'h2004);
    tv[17] = mk(5'b11011, 1'b1, 14'h24, 32'h2004, 1'b1, 32'h1004, 32'h2008);
    tv[18] = mk(5'b11011, 1'b1, 14'h20, 32'h1,    1'b1, 32'h1004, 32'h200C);
    tv[19] = mk(5'b11011, 1'b0, 14'h00, 32'h0,    1'b0, 32'h1004, 32'h2000);
    tv[20] = mk(5'b11001, 1'b1, 14'h00, 32'h3,    1'b1, 32'h1004, 32'h2000);
    tv[21] = mk(5'b11001, 1'b1, 14'h24, 32'h2000, 1'b1, 32'h1004, 32'h2000);
    tv[22] = mk(5'b11001, 1'b1, 14'h20, 32'h1,    1'b1, 32'h1004, 32'h2000);
    tv[23] = mk(5'b11001, 1'b0, 14'h00, 32'h0,    1'b0, 32'h1004, 32'h2000);

    // reset state
    @(negedge clk);
    chk("rst_req", csr_req, 1'b0);
    chk("rst_addr", csr_addr, 14'h0);
    chk("rst_data", csr_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_play_addr", play_addr, 32'h0);
    chk("rst_rec_addr", rec_addr, 32'h0);
    chk("rst_err", err, 1'b0);

    do_reset(32'h1000, 32'h2000);
    for (int i = 0; i < 24; i++) begin
      {play_en, rec_en, dmar_irq, dmaw_irq, csr_ack} = tv[i].in;
      tick();
      chk($sformatf("vec%0d_req", i), csr_req, tv[i].req);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].bsy);
      if (tv[i].req) begin
        chk($sformatf("vec%0d_addr", i), csr_addr, tv[i].a);
        chk($sformatf("vec%0d_data", i), csr_data, tv[i].d);
      end
      chk($sformatf("vec%0d_play_addr", i), play_addr, tv[i].pa);
      chk($sformatf("vec%0d_rec_addr", i), rec_addr, tv[i].ra);
    end

    // both channels pending: play first, simultaneous irqs mid-sequence then serve rec first
    do_reset(32'h1000, 32'h2000);
    play_en = 1'b1; rec_en = 1'b1; csr_ack = 1'b1;
    got_q.delete();
    for (int cyc = 0; cyc < 16; cyc++) begin
      dmar_irq = (cyc == 3); dmaw_irq = (cyc == 3);
      if (csr_req && csr_ack) got_q.push_back('{csr_addr, csr_data});
      tick();
    end
    exp_q = '{'{14'h00, 32'h1}, '{14'h14, 32'h1000}, '{14'h10, 32'h1},
              '{14'h00, 32'h3}, '{14'h24, 32'h2004}, '{14'h20, 32'h1},
              '{14'h00, 32'h1}, '{14'h14, 32'h1004}, '{14'h10, 32'h1}};
    chk("rr_write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("rr_w%0d_addr", i), got_q[i].a, exp_q[i].a);
      chk($sformatf("rr_w%0d_data", i), got_q[i].d, exp_q[i].d);
    end
    chk("rr_busy_end", busy, 1'b0);

    // reset asserted while the START write is on the bus
    do_reset(32'h1000, 32'h2000);
    play_en = 1'b1; csr_ack = 1'b1;
    repeat (4) tick();
    chk("mid_start_addr", csr_addr, 14'h10);
    chk("mid_start_req", csr_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", csr_req, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_addr", csr_addr, 14'h0);
    chk("async_rst_data", csr_data, 32'h0);
    chk("async_rst_play_addr", play_addr, 32'h0);
    chk("async_rst_rec_addr", rec_addr, 32'h0);
    chk("async_rst_err", err, 1'b0);

    // stuck csr_ack
    do_reset(32'h1000, 32'h2000);
    play_en = 1'b1; csr_ack = 1'b0;
    repeat (2) tick();
    chk("stall_req", csr_req, 1'b1);
`ifdef AC97_SCHED_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      while (busy && waited < 300) begin
        tick();
        waited++;
        if (waited == 200) chk("wdog_err_early", err, 1'b0);
      end
      chk("wdog_finished_in_time", waited < 300, 1'b1);
      chk("wdog_err", err, 1'b1);
      chk("wdog_req", csr_req, 1'b0);
      chk("wdog_busy", busy, 1'b0);
    end
`else
    repeat (300) tick();
    chk("wait_req", csr_req, 1'b1);
    chk("wait_busy", busy, 1'b1);
    chk("wait_addr", csr_addr, 14'h00);
    chk("wait_err", err, 1'b0);
`endif

    // randomized runs against the model, including a ring that wraps the 32-bit space
    for (int run = 0; run < 2; run++) begin
      if (run == 0) do_reset($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
      else          do_reset(32'hFFFF_FFF8, 32'h0000_0040);
      model_on = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if ($urandom_range(0, 39) == 0) play_en = ~play_en;
        if ($urandom_range(0, 39) == 0) rec_en = ~rec_en;
        dmar_irq = ($urandom_range(0, 4) == 0);
        dmaw_irq = ($urandom_range(0, 4) == 0);
        csr_ack  = ($urandom_range(0, 2) != 0);
        tick();
      end
      model_on = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
